// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store initiator; byte/half stores via read-modify-write.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_RMW_R = 3'd3,
        S_RMW_W = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [15:0] r_wdata_lo;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;
    logic [CW-1:0] r_cnt;

    logic        w_misaligned;
    logic        w_timeout;
    logic [4:0]  w_bsel;
    logic [4:0]  w_hsel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_misaligned = (size_i == 2'b11) ||
                          (size_i == 2'b01 && addr_i[0]) ||
                          (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    // An ack in the last allowed cycle takes priority over the abort.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_cnt_last) && !mem_ack_i;

    assign w_bsel = {r_addr[1:0], 3'b000};
    assign w_hsel = {r_addr[1], 4'b0000};
    assign w_byte = mem_rdata_i[w_bsel +: 8];
    assign w_half = mem_rdata_i[w_hsel +: 16];

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = mem_rdata_i;
        endcase
    end

    always_comb begin
        w_merged = mem_rdata_i;
        if (r_size == 2'b00)
            w_merged[w_bsel +: 8] = r_wdata_lo[7:0];
        else
            w_merged[w_hsel +: 16] = r_wdata_lo;
    end

    assign mem_addr_o  = {r_addr[31:2], 2'b00};
    assign mem_wdata_o = r_mem_wdata;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        done_o       = 1'b0;
        stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = req_i;
                if (req_i) begin
                    if (w_misaligned)
                        w_state_next = S_DONE;
                    else if (we_i)
                        w_state_next = (size_i == 2'b10) ? S_WRITE : S_RMW_R;
                    else
                        w_state_next = S_READ;
                end
            end
            S_READ, S_WRITE, S_RMW_W: begin
                mem_req_o = 1'b1;
                mem_we_o  = (r_state != S_READ);
                stall_o   = 1'b1;
                if (mem_ack_i || w_timeout)
                    w_state_next = S_DONE;
            end
            S_RMW_R: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                if (mem_ack_i)
                    w_state_next = S_RMW_W;
                else if (w_timeout)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata_lo  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 2'b00;
            r_cnt       <= '0;
        end else begin
            // Wait counter restarts whenever the state changes.
            r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE && req_i) begin
                r_size      <= size_i;
                r_unsigned  <= unsigned_i;
                r_addr      <= addr_i;
                r_wdata_lo  <= wdata_i[15:0];
                r_mem_wdata <= wdata_i;
                r_rdata     <= '0;
                r_err       <= w_misaligned ? 2'b01 : 2'b00;
            end
            if (mem_req_o && w_timeout) begin
                r_err   <= 2'b10;
                r_rdata <= '0;
            end
            if (mem_ack_i && r_state == S_READ)
                r_rdata <= w_load;
            if (mem_ack_i && r_state == S_RMW_R)
                r_mem_wdata <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: it turns MEM-stage load/store requests into handshaked word transactions on a data memory. The memory stores little-endian bytes, has no byte enables and may take several cycles to acknowledge. The unit sits between the pipeline's MEM stage and the data memory. It freezes the pipeline through `stall_o` while a transaction is outstanding. Byte and halfword stores are done as read-modify-write. Loads are lane-selected and then sign- or zero-extended.

## Interface
- `TIMEOUT`, default 16: cycles to wait for `mem_ack_i` before aborting; 0 disables the timeout.
- `clk_i` input 1: the only clock; every register updates on its rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `req_i` input 1: MEM stage has an access. Held, with all fields stable, while `stall_o` is high.
- `we_i` input 1: 1 = store, 0 = load.
- `size_i` input 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `unsigned_i` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `addr_i` input 32: byte address.
- `wdata_i` input 32: store data, right-justified.
- `stall_o` output 1: freeze the pipeline.
- `done_o` output 1: one-cycle pulse; the access has completed.
- `rdata_o` output 32: extended load data, valid while `done_o` is high.
- `err_o` output 2: valid with `done_o`. 00 = ok, 01 = misaligned or reserved size, 10 = timeout.
- `mem_req_o` output 1: memory request.
- `mem_we_o` output 1: memory write.
- `mem_addr_o` output 32: word address, equal to `{addr[31:2], 2'b00}`.
- `mem_wdata_o` output 32: full word to write.
- `mem_rdata_i` input 32: read word, valid in the cycle `mem_ack_i` is high.
- `mem_ack_i` input 1: memory completes the current request.

## Operation
- States: IDLE, READ, WRITE, RMW_R, RMW_W, DONE.
- **IDLE, `req_i` = 0:** remain in IDLE.
- **IDLE, `req_i` = 1:** latch `we_i`, `size_i`, `unsigned_i`, `addr_i`, `wdata_i`, then branch:
  - misaligned access goes to DONE with `err_o` = 01 and issues no memory access. Misaligned means a half with `addr[0]` = 1, a word with `addr[1:0]` ≠ 0, or `size_i` = 11.
  - word store goes to WRITE.
  - byte or half store goes to RMW_R.
  - any load goes to READ.
- **Request states (READ, WRITE, RMW_R, RMW_W):**
  - `mem_req_o` = 1; `mem_addr_o`, `mem_we_o` and `mem_wdata_o` stay constant until ack.
  - `mem_we_o` = 1 only in WRITE and RMW_W.
- **READ on ack:** extract the load value and go to DONE.
  - Byte: lane k = `addr[1:0]`, value = `word[8k+7:8k]`.
  - Half: value = `word[16h+15:16h]`, where h = `addr[1]`.
  - Extend to 32 bits as selected by `unsigned_i`; a word load is passed unchanged.
- **RMW_R on ack:** build the merged word and go to RMW_W.
  - Byte: replace lane k with `wdata[7:0]`.
  - Half: replace half h with `wdata[15:0]`.
  - All other bytes keep the value that was read.
- **WRITE or RMW_W on ack:** go to DONE.
- **Timeout:** a wait counter clears on entry to each request state and increments on every cycle without ack. If `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT` - 1 with no ack, the unit drops `mem_req_o`, goes to DONE with `err_o` = 10 and sets `rdata_o` = 0. An ack arriving in that same cycle wins over the timeout.
- **DONE:**
  - `done_o` = 1.
  - Next state is always IDLE. `req_i` is ignored in DONE because it still belongs to the completed access.
- **Outputs, combinational on state:**
  - `stall_o` = (IDLE && `req_i`) || (state is READ, WRITE, RMW_R or RMW_W).
  - `stall_o` = 0 in DONE.
- **Reset values, following the reset edge:**
  - state = IDLE.
  - `mem_req_o`, `mem_we_o`, `done_o` and `stall_o` = 0, except that `stall_o` still follows `req_i` while in IDLE.
  - `mem_addr_o`, `mem_wdata_o` and `rdata_o` = 0; `err_o` = 00.
- **Reset mid-transaction:** the transaction is abandoned; a late `mem_ack_i` that arrives in IDLE is ignored.

## Timing
- **Handshake:** the unit holds `mem_req_o` high until it samples `mem_ack_i` = 1 on a rising edge. `mem_req_o` is low in the cycle after the ack, or goes straight to the next RMW phase.
- **Memory latency:** an ack may arrive in the first request cycle (zero wait) or any number of cycles later.
- **Zero-wait load or word store:** accept in cycle 0, request in cycle 1, `done_o` in cycle 2. `stall_o` is high in cycles 0 and 1.
- **Zero-wait RMW store:** RMW_R in cycle 1, RMW_W in cycle 2, DONE in cycle 3.
- **Wait states:** each cycle without ack extends the sequence by one cycle.
- **Misaligned access:** accept in cycle 0, DONE in cycle 1, one stall cycle, no `mem_req_o` pulse.
- **Back-to-back requests:** a new request is accepted at the earliest in the cycle after DONE.

## Test plan
- Load word, addr 0x8, memory returns 0xDEADBEEF with zero wait -> `rdata_o` = 0xDEADBEEF and `err_o` = 00 in cycle 2; `stall_o` high in cycles 0-1.
- Signed byte load (lb), addr 0x5, word 0x00008000 -> `rdata_o` = 0xFFFFFF80. Same access with `unsigned_i` = 1 (lbu) -> 0x00000080.
- Store byte (sb) 0xAA to addr 0x6, existing word 0x11223344, ack after 2 wait states in each phase:
  - a read is issued, then a write with `mem_wdata_o` = 0x11AA3344 to `mem_addr_o` = 0x4.
  - `done_o` follows the write ack by one cycle.
- Load half (lh), addr 0x3 -> `done_o` in cycle 1 with `err_o` = 01, `mem_req_o` never asserted.
- Load with no ack and `TIMEOUT` = 4 -> `mem_req_o` high for exactly 4 cycles, then `done_o` with `err_o` = 10 and `rdata_o` = 0.
- `rst_i` pulsed during RMW_W wait -> IDLE and `mem_req_o` = 0 after the edge. A late ack is ignored. The next word store 0x12345678 to 0x0 completes normally.
